// File: rtl/fetch_stage_pkg.sv
// Shared opcodes, fetch state encoding and IF/ID defaults
// for the WISC instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;

  localparam logic [15:0] NOP_WORD = {OP_NOP, 11'h000};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [15:0] w);
    return w[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_latch.sv
// IF/ID pipeline register: {instruction, pcPlus2, valid}
// with load, hold and NOP-inject controls.
module if_id_latch #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        inject_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc2_i,
  output logic [15:0] instr_o,
  output logic [15:0] pc2_o,
  output logic        valid_o
);

  logic [15:0] instr_q;
  logic [15:0] pc2_q;
  logic        valid_q;

  // inject beats load so a flush always leaves a bubble
  always_ff @(posedge clk) begin
    if (rst || inject_i) begin
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc2_q   <= pc2_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc2_o   = pc2_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// WISC fetch stage: PC, halt wind-down, redirect/stall
// handling and IF/ID latch feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] redirectPC,
  input  logic [15:0] instrMemData,
  output logic [15:0] instrMemAddr,
  output logic        instrMemEn,
  output logic [15:0] instruction,
  output logic [15:0] pcPlus2,
  output logic        valid,
  output logic        halted,
  output logic [15:0] fetchCount,
  output logic        err
);

  fetch_state_e state_q;
  logic [15:0]  pc_q;
  logic [15:0]  cnt_q;
  logic         err_q;

  logic [15:0]  pc_plus2;
  logic         load;
  logic         inject;

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    load   = 1'b0;
    inject = 1'b0;
    if (flush) begin
      inject = 1'b1;
    end else if (!stall) begin
      if (state_q == ST_RUN) load = 1'b1;
      else                   inject = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= PC_RESET;
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_RUN;
      pc_q    <= redirectPC;
      if (redirectPC[0]) err_q <= 1'b1;
    end else if (!stall && state_q == ST_RUN) begin
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      // HALT parks the PC on itself
      if (is_halt(instrMemData)) state_q <= ST_HALTED;
      else                       pc_q    <= pc_plus2;
    end
  end

  if_id_latch #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .inject_i(inject),
    .instr_i (instrMemData),
    .pc2_i   (pc_plus2),
    .instr_o (instruction),
    .pc2_o   (pcPlus2),
    .valid_o (valid)
  );

  assign instrMemAddr = pc_q;
  assign instrMemEn   = (state_q == ST_RUN);
  assign halted       = (state_q == ST_HALTED);
  assign fetchCount   = cnt_q;
  assign err          = err_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the WISC pipeline, directly upstream of instruction decode. It holds the PC, drives the instruction memory address, and registers the fetched instruction and PC+2 into an IF/ID latch consumed by decode. It also handles stalls from the hazard unit, redirects from branch/jump resolution, and the HALT wind-down so that decode sees HALT exactly once followed by NOPs.

## Interface
- `PC_RESET`, default 16'h0000: PC value after reset.
- `NOP_INSTR`, default 16'h0800: instruction injected on flush, reset or after halt (opcode 00001).
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard unit request to hold PC and IF/ID.
- `flush`  in  1: redirect request from branch/jump resolution; kills the current fetch.
- `redirectPC`  in  16: target PC, valid when `flush`=1.
- `instrMemData`  in  16: combinational read data from instruction memory at `instrMemAddr`.
- `instrMemAddr`  out  16: equals the PC register (combinational).
- `instrMemEn`  out  1: 1 in RUN, 0 in HALTED.
- `instruction`  out  16: IF/ID instruction to decode.
- `pcPlus2`  out  16: IF/ID PC+2 of `instruction`.
- `valid`  out  1: IF/ID holds a real fetched instruction.
- `halted`  out  1: state is HALTED.
- `fetchCount`  out  16: number of instructions delivered with `valid`=1; saturates at 16'hFFFF.
- `err`  out  1: sticky misalignment error.

## Operation
- States: RUN, HALTED; encoded 1 bit.
- Fetch is HALT when `instrMemData[15:11]`==5'b00000.
- Priority per cycle: `rst` > `flush` > `stall` > normal.
- `flush` (any state): PC <= `redirectPC`; IF/ID <= {`NOP_INSTR`, 16'h0000, valid=0}; state <= RUN. If `redirectPC[0]`=1, `err` <= 1 (PC is still loaded).
- `stall` without `flush`: PC, IF/ID, state and `fetchCount` hold.
- RUN, normal, non-HALT fetch: PC <= PC+2; IF/ID <= {`instrMemData`, PC+2, valid=1}.
- RUN, normal, HALT fetch: PC holds; IF/ID <= {HALT, PC+2, valid=1}; state <= HALTED.
- HALTED, normal: PC holds; IF/ID <= {`NOP_INSTR`, 16'h0000, valid=0}.
- `fetchCount` increments on each edge that loads IF/ID with valid=1, and saturates.
- PC+2 is modulo 2^16: 16'hFFFE+2 = 16'h0000, with no error.
- `err` clears only on `rst`.

## Timing
- Reset values: PC=`PC_RESET`, `instruction`=`NOP_INSTR`, `pcPlus2`=0, `valid`=0, state RUN, `halted`=0, `fetchCount`=0, `err`=0.
- Memory read is same-cycle. The instruction at PC appears on `instruction` one edge later, so fetch latency is 1 cycle.
- Throughput is 1 instruction per cycle absent stall or flush.
- A flush in cycle N makes the target instruction appear on `instruction` after edge N+1, leaving one bubble.
- `halted` rises on the edge that latches HALT into IF/ID.
- Simultaneous `stall` and `flush`: flush wins.
- Stall during HALTED: hold.
- Flush during HALTED resumes RUN; this covers an older branch that resolves after HALT was fetched.
- `rst` asserted mid-operation restores all reset values on that edge, regardless of `stall` or `flush`.

## Structure
- Shared defines file holds: `OP_HALT` (5'b00000), `OP_NOP` (5'b00001), the fetch state encoding, and the default NOP word.
- One sub-module, `if_id_latch`: registers {instruction, pcPlus2, valid} with load/hold/inject-NOP controls and synchronous reset.
- PC register, state register, counter and `err` live in `fetch_stage`.

## Test plan
- Reset, then memory returns 16'h4000, 16'h4100, 16'h4200 at 0, 2, 4 → `instruction` sequence 4000/4100/4200, `pcPlus2` 2/4/6, `valid`=1, `fetchCount`=3.
- `stall` held 3 cycles at PC=4 → PC, `instruction` and `fetchCount` frozen; PC resumes at 6 after release.
- `flush` with `redirectPC`=16'h0040 and `stall`=1 in the same cycle → PC=16'h0040, `valid`=0 next cycle, target instruction valid the cycle after.
- HALT at 16'h0010 → HALT on `instruction` once with `pcPlus2`=16'h0012, then NOPs with `valid`=0; `halted`=1; PC stays 16'h0010; `instrMemEn`=0.
- In HALTED, `flush` to 16'h0020 → state RUN, fetch resumes at 16'h0020. Flush to 16'h0021 → `err`=1 and it stays set until `rst`.
- PC=16'hFFFE, normal fetch → PC wraps to 16'h0000 with `err`=0. `rst` mid-stream → all outputs return to their reset values on that edge.
